// File: rtl/nios_system_tec2_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_tec2_tick_counter
// Description : Avalon-MM slave that counts rising edges of an upstream timer
//               irq level, with a 32-bit compare/match interrupt, overflow
//               flag and optional auto-clear on match.
//               Optional feature macro: TICK_COUNTER_SNAPSHOT_EN -- when
//               defined, reading count[15:0] latches count[31:16] into a
//               shadow so a following high-half read is coherent.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_system_tec2_tick_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  input  logic        tick_in,
  output logic        irq,
  output logic [15:0] readdata
);

  localparam logic [31:0] C_COMPARE_RST = 32'hFFFF_FFFF;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  ctrl_q, ctrl_d;        // {auto_clear, irq_enable}
  logic        running_q, running_d;
  logic        match_q, match_d;
  logic        overflow_q, overflow_d;
  logic        tick_prev_q, tick_prev_d;
  logic [15:0] readdata_q, readdata_d;

  logic        w_wr_en;
  logic        w_tick;
  logic        w_count_wr;
  logic [31:0] w_count_inc;
  logic [15:0] w_count_hi_rd;

  assign w_wr_en     = chipselect & ~write_n;
  assign w_tick      = tick_in & ~tick_prev_q;
  assign w_count_wr  = w_wr_en & ((address == 3'd2) | (address == 3'd3));
  assign w_count_inc = count_q + 32'd1;

`ifdef TICK_COUNTER_SNAPSHOT_EN
  logic [15:0] shadow_q, shadow_d;
  logic        w_rd_en;

  assign w_rd_en       = chipselect & write_n;
  assign w_count_hi_rd = shadow_q;

  // Capture the high half whenever the low half is read.
  always_comb begin
    shadow_d = shadow_q;
    if (w_rd_en && (address == 3'd2)) begin
      shadow_d = count_q[31:16];
    end
  end

  // Shadow register for coherent 32-bit count reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= 16'd0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  assign w_count_hi_rd = count_q[31:16];
`endif

  // Register-file writes, tick counting and flag updates.
  always_comb begin
    count_d     = count_q;
    compare_d   = compare_q;
    ctrl_d      = ctrl_q;
    running_d   = running_q;
    match_d     = match_q;
    overflow_d  = overflow_q;
    tick_prev_d = tick_in;

    if (w_wr_en) begin
      case (address)
        3'd0: begin
          match_d    = 1'b0;
          overflow_d = 1'b0;
        end
        3'd1: begin
          ctrl_d = writedata[1:0];
          // Start has priority over stop when both are requested.
          if (writedata[2]) begin
            running_d = 1'b1;
          end else if (writedata[3]) begin
            running_d = 1'b0;
          end
        end
        3'd2:    count_d[15:0]    = writedata;
        3'd3:    count_d[31:16]   = writedata;
        3'd4:    compare_d[15:0]  = writedata;
        3'd5:    compare_d[31:16] = writedata;
        default: ;
      endcase
    end

    // A software load of count discards a coincident tick entirely.
    // Events are applied after the status-write clear so they win.
    if (w_tick && running_q && !w_count_wr) begin
      count_d = w_count_inc;
      if (w_count_inc == compare_q) begin
        match_d = 1'b1;
        if (ctrl_q[1]) begin
          count_d = 32'd0;
        end
      end
      if (count_q == 32'hFFFF_FFFF) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Read mux, sampled into readdata every cycle.
  always_comb begin
    readdata_d = 16'd0;
    case (address)
      3'd0:    readdata_d = {13'd0, running_q, overflow_q, match_q};
      3'd1:    readdata_d = {14'd0, ctrl_q};
      3'd2:    readdata_d = count_q[15:0];
      3'd3:    readdata_d = w_count_hi_rd;
      3'd4:    readdata_d = compare_q[15:0];
      3'd5:    readdata_d = compare_q[31:16];
      default: readdata_d = 16'd0;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= 32'd0;
      compare_q   <= C_COMPARE_RST;
      ctrl_q      <= 2'd0;
      running_q   <= 1'b0;
      match_q     <= 1'b0;
      overflow_q  <= 1'b0;
      tick_prev_q <= 1'b0;
      readdata_q  <= 16'd0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      ctrl_q      <= ctrl_d;
      running_q   <= running_d;
      match_q     <= match_d;
      overflow_q  <= overflow_d;
      tick_prev_q <= tick_prev_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = match_q & ctrl_q[0];

endmodule
`default_nettype wire

// File: doc/nios_system_tec2_tick_counter.md
NIOS_SYSTEM_TEC2_TICK_COUNTER -- requirements
Module: nios_system_tec2_tick_counter

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port address, input, 3 bits: Avalon-MM register word index.
REQ-005 SHALL have port chipselect, input, 1 bit: slave select.
REQ-006 SHALL have port write_n, input, 1 bit: active-low write; chipselect && write_n is a read.
REQ-007 SHALL have port writedata, input, 16 bits: write data.
REQ-008 SHALL have port tick_in, input, 1 bit: upstream timer irq level, synchronous to clk.
REQ-009 SHALL have port irq, output, 1 bit: match interrupt request.
REQ-010 SHALL have port readdata, output, 16 bits: registered read data.

Function
REQ-011 SHALL decode registers as follows.
- 0: status = {running, overflow, match}.
- 1: control[1:0] = {auto_clear, irq_enable}.
- 2: count[15:0].
- 3: count[31:16].
- 4: compare[15:0].
- 5: compare[31:16].
- 6 and 7: read 0, writes ignored.
REQ-012 SHALL register readdata every cycle from the address mux, giving read latency 1 clk.
REQ-013 SHALL detect a tick as tick_in=1 with the previous-cycle registered tick_in=0, so a held level counts once.
REQ-014 SHALL, on a tick while running, set count to count+1, modulo 2^32.
REQ-015 SHALL, when count+1 == compare on a tick, set match; if auto_clear=1, count SHALL load 0 instead of compare.
REQ-016 SHALL, when count goes from 0xFFFFFFFF to 0 on a tick, set overflow.
REQ-017 SHALL treat a control write with writedata[2]=1 as start (running<=1) and writedata[3]=1 as stop (running<=0); start SHALL win if both bits are set; only bits [1:0] SHALL be stored.
REQ-018 SHALL, on a write to address 0 (any data), clear match and overflow; a match/overflow event in the same cycle SHALL win, leaving the flag set.
REQ-019 SHALL, on a write to address 2 or 3, load that half of count; a tick in the same cycle SHALL be discarded (write wins, no match/overflow evaluation).
REQ-020 SHALL drive irq = match && irq_enable, combinationally from registers.
REQ-021 SHALL ignore ticks while stopped; count SHALL hold.

Reset
REQ-022 SHALL, on reset_n=0, asynchronously set:
- count=0, compare=0xFFFFFFFF, control=0;
- running=0, match=0, overflow=0;
- tick_in history=0, readdata=0, irq=0.
REQ-023 SHALL, when reset is asserted mid-count, abandon any pending tick; the first tick after release SHALL require a fresh 0->1 edge seen after release.

Configuration
REQ-024 SHALL support macro TICK_COUNTER_SNAPSHOT_EN.
- Defined: a read of address 2 SHALL latch count[31:16] into a 16-bit shadow in the same cycle it returns count[15:0], and a read of address 3 SHALL return the shadow.
- Undefined: address 3 SHALL return live count[31:16], and no shadow register SHALL exist.
- Shadow reset value: 0.

Verification
REQ-025 SHALL cover: compare=3, start, 3 ticks -> count=3, match=1, irq=0 (irq_enable=0); then control=0x1 -> irq=1.
REQ-026 SHALL cover: auto_clear=1, compare=2, 5 ticks -> count=1, match=1; status write -> match=0, irq=0.
REQ-027 SHALL cover: count loaded 0xFFFFFFFF, start, 1 tick -> count=0, overflow=1, readdata at address 3 = 0x0000 one clk after the read.
REQ-028 SHALL cover: tick_in held high 10 clks while running -> count increments by exactly 1; tick in the same cycle as a count_l write of 0x0005 -> count[15:0]=5.
REQ-029 SHALL cover: with TICK_COUNTER_SNAPSHOT_EN, count=0x0001FFFF, read address 2, tick, read address 3 -> 0x0001 (without the macro -> 0x0002).
REQ-030 SHALL cover: reset_n pulsed low mid-run with tick_in=1 -> all registers at reset values, and no count until tick_in falls then rises.
